// File: rtl/shot_hit_detector_pkg.sv
// Shared constants and FSM encoding for the shot hit detector slice.
package shot_pkg;

    localparam int NUM_SHOTS = 8;
    localparam int IDX_W     = $clog2(NUM_SHOTS);
    localparam int COORD_W   = 10;
    localparam int CMP_W     = 12;
    localparam int SHOT_W    = 4;
    localparam int SHOT_H    = 10;
    localparam int DUCK_W    = 32;
    localparam int DUCK_H    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_REPORT = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/shot_hit_detector_if.sv
// Shot-position bus: slot coordinates from the shot builder plus the retire handshake back to it.
interface shot_hit_if;
    import shot_pkg::*;

    logic [COORD_W*NUM_SHOTS-1:0] shot_x_flat;
    logic [COORD_W*NUM_SHOTS-1:0] shot_y_flat;
    logic [NUM_SHOTS-1:0]         shot_active;
    logic                         retire_req;
    logic [IDX_W-1:0]             retire_slot;
    logic                         retire_ack;

    // master is the shot builder, slave is the hit detector
    modport master (
        output shot_x_flat, shot_y_flat, shot_active, retire_ack,
        input  retire_req, retire_slot
    );

    modport slave (
        input  shot_x_flat, shot_y_flat, shot_active, retire_ack,
        output retire_req, retire_slot
    );

endinterface

// File: rtl/shot_hit_detector_overlap.sv
// Combinational box test between one shot and the duck, done in 12-bit signed so
// neither the 1023 edge nor negative shot y can wrap.
module shot_box_overlap
    import shot_pkg::*;
(
    input  logic [COORD_W-1:0]        shot_x,
    input  logic signed [COORD_W-1:0] shot_y,
    input  logic [COORD_W-1:0]        duck_x,
    input  logic [COORD_W-1:0]        duck_y,
    output logic                      overlap
);

    localparam logic signed [CMP_W-1:0] SW = CMP_W'(SHOT_W);
    localparam logic signed [CMP_W-1:0] SH = CMP_W'(SHOT_H);
    localparam logic signed [CMP_W-1:0] DW = CMP_W'(DUCK_W);
    localparam logic signed [CMP_W-1:0] DH = CMP_W'(DUCK_H);

    logic signed [CMP_W-1:0] sx;
    logic signed [CMP_W-1:0] sy;
    logic signed [CMP_W-1:0] dx;
    logic signed [CMP_W-1:0] dy;

    assign sx = signed'({{(CMP_W-COORD_W){1'b0}}, shot_x});
    assign sy = signed'({{(CMP_W-COORD_W){shot_y[COORD_W-1]}}, shot_y});
    assign dx = signed'({{(CMP_W-COORD_W){1'b0}}, duck_x});
    assign dy = signed'({{(CMP_W-COORD_W){1'b0}}, duck_y});

    assign overlap = (sx < dx + DW) && (sx + SW > dx) &&
                     (sy < dy + DH) && (sy + SH > dy);

endmodule

// File: rtl/shot_hit_detector.sv
// Scans the shot slots once per SCAN_DIV tick, reports hits and retires the hit slot.
// Define SHOT_HIT_MULTI_HIT_EN to keep scanning after a hit so every overlapping slot is retired.
module shot_hit_detector
    import shot_pkg::*;
#(
    parameter int SCAN_DIV = 60000,
    parameter int SCORE_W  = 8
)
(
    input  logic               clk,
    input  logic               reset,
    shot_hit_if.slave          shot_bus,
    input  logic [COORD_W-1:0] duck_x,
    input  logic [COORD_W-1:0] duck_y,
    input  logic               duck_alive,
    output logic               hit,
    output logic               duck_kill,
    output logic [SCORE_W-1:0] score,
    output logic               busy
);

`ifdef SHOT_HIT_MULTI_HIT_EN
    localparam bit MULTI_HIT = 1'b1;
`else
    localparam bit MULTI_HIT = 1'b0;
`endif

    localparam int               CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SHOTS - 1);

    state_t                     state;
    state_t                     state_nxt;
    logic [CNT_W-1:0]           tick_cnt;
    logic                       tick;
    logic [IDX_W-1:0]           idx;
    logic [COORD_W-1:0]         slot_x;
    logic signed [COORD_W-1:0]  slot_y;
    logic                       overlap;
    logic                       hit_now;
    logic                       kill_done;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + SCORE_W'(1);
    endfunction

    // Free-running pass timer; ticks arriving while busy are simply not looked at.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            tick_cnt <= '0;
        else if (tick)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + CNT_W'(1);
    end

    assign tick = (tick_cnt == CNT_LAST);

    assign slot_x = shot_bus.shot_x_flat[COORD_W*int'(idx) +: COORD_W];
    assign slot_y = signed'(shot_bus.shot_y_flat[COORD_W*int'(idx) +: COORD_W]);

    shot_box_overlap u_overlap (
        .shot_x  (slot_x),
        .shot_y  (slot_y),
        .duck_x  (duck_x),
        .duck_y  (duck_y),
        .overlap (overlap)
    );

    assign hit_now = (state == ST_SCAN) && duck_alive && shot_bus.shot_active[idx] && overlap;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (tick) state_nxt = ST_SCAN;
            ST_SCAN: begin
                if (hit_now)
                    state_nxt = ST_REPORT;
                else if (idx == IDX_LAST)
                    state_nxt = ST_IDLE;
            end
            ST_REPORT: if (shot_bus.retire_ack) state_nxt = ST_DONE;
            ST_DONE:   state_nxt = (MULTI_HIT && (idx != IDX_LAST)) ? ST_SCAN : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy                = (state != ST_IDLE);
        shot_bus.retire_req = (state == ST_REPORT);
    end

    // Hit pulses land in the first REPORT cycle; idx steps past a retired slot in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx                  <= '0;
            shot_bus.retire_slot <= '0;
            hit                  <= 1'b0;
            duck_kill            <= 1'b0;
            score                <= '0;
            kill_done            <= 1'b0;
        end else begin
            hit       <= hit_now;
            duck_kill <= hit_now && !kill_done;
            if (hit_now) begin
                shot_bus.retire_slot <= idx;
                score                <= sat_inc(score);
                kill_done            <= 1'b1;
            end
            if ((state == ST_IDLE) && tick) begin
                idx       <= '0;
                kill_done <= 1'b0;
            end else if (((state == ST_SCAN) && !hit_now) || (state == ST_DONE)) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_shot_hit_detector.sv
// Randomized self-checking bench for shot_hit_detector against a pass-level reference model.
module tb_shot_hit_detector;

    localparam int SCAN_DIV = 16;
    localparam int SCORE_W  = 8;
    localparam int NS       = 8;
    localparam int SAT      = (1 << SCORE_W) - 1;
`ifdef SHOT_HIT_MULTI_HIT_EN
    localparam bit MULTI = 1'b1;
`else
    localparam bit MULTI = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [9:0] duck_x;
    logic [9:0] duck_y;
    logic duck_alive;
    logic hit;
    logic duck_kill;
    logic [SCORE_W-1:0] score;
    logic busy;

    shot_hit_if bus ();

    shot_hit_detector #(.SCAN_DIV(SCAN_DIV), .SCORE_W(SCORE_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .shot_bus   (bus.slave),
        .duck_x     (duck_x),
        .duck_y     (duck_y),
        .duck_alive (duck_alive),
        .hit        (hit),
        .duck_kill  (duck_kill),
        .score      (score),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ecnt;
    int score_m = 0;
    int last_start = 0;
    int sx [NS];
    int sy [NS];
    bit act [NS];
    int dx, dy;
    bit alive;

    always @(posedge clk or negedge reset)
        if (!reset) ecnt <= 0;
        else        ecnt <= ecnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_hit(input int k);
        return alive && act[k] && (sx[k] < dx + 32) && (sx[k] + 4 > dx) &&
               (sy[k] < dy + 32) && (sy[k] + 10 > dy);
    endfunction

    task automatic apply();
        logic [10*NS-1:0] xf;
        logic [10*NS-1:0] yf;
        logic [NS-1:0]    af;
        int tx, ty;
        for (int k = 0; k < NS; k++) begin
            tx = sx[k];
            ty = sy[k];
            xf[10*k +: 10] = tx[9:0];
            yf[10*k +: 10] = ty[9:0];
            af[k] = act[k];
        end
        bus.shot_x_flat = xf;
        bus.shot_y_flat = yf;
        bus.shot_active = af;
        duck_x = dx[9:0];
        duck_y = dy[9:0];
        duck_alive = alive;
    endtask

    task automatic clear_all();
        for (int k = 0; k < NS; k++) begin
            sx[k] = 0;
            sy[k] = 0;
            act[k] = 1'b0;
        end
        dx = 96;
        dy = 40;
        alive = 1'b1;
    endtask

    task automatic set_basic();
        clear_all();
        act[2] = 1'b1;
        sx[2] = 100;
        sy[2] = 50;
        apply();
    endtask

    task automatic randomize_inputs();
        dx = $urandom_range(0, 991);
        dy = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : int'($urandom_range(0, 460));
        alive = ($urandom_range(0, 15) != 0);
        for (int k = 0; k < NS; k++) begin
            act[k] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                sx[k] = dx + int'($urandom_range(0, 41)) - 6;
                sy[k] = dy + int'($urandom_range(0, 47)) - 14;
            end else begin
                sx[k] = $urandom_range(0, 1023);
                sy[k] = int'($urandom_range(0, 522)) - 11;
            end
            if (sx[k] < 0)    sx[k] = 0;
            if (sx[k] > 1023) sx[k] = 1023;
            if (sy[k] < -11)  sy[k] = -11;
            if (sy[k] > 511)  sy[k] = 511;
        end
        apply();
    endtask

    // Expects to be entered at a negedge with the DUT idle and inputs already applied.
    task automatic run_pass(input int ack_dly);
        int exp_q[$];
        int base, c, s, bad;
        bit first;
        for (int k = 0; k < NS; k++)
            if (model_hit(k)) exp_q.push_back(k);
        if (!MULTI)
            while (exp_q.size() > 1) void'(exp_q.pop_back());
        c = 0;
        while (busy !== 1'b1 && c < 40) begin
            bus.retire_ack = 1'($urandom_range(0, 1));
            @(negedge clk);
            c++;
        end
        bus.retire_ack = 1'b0;
        chk("pass_start", busy, 1);
        if (busy !== 1'b1) return;
        last_start = ecnt;
        chk("pass_phase", ecnt % SCAN_DIV, 0);
        base = 0;
        first = 1'b1;
        forever begin
            if (exp_q.size() == 0) begin
                bad = 0;
                repeat (NS - base) begin
                    if (busy !== 1'b1 || hit !== 1'b0 || duck_kill !== 1'b0) bad++;
                    bus.retire_ack = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                bus.retire_ack = 1'b0;
                chk("scan_tail", bad, 0);
                chk("pass_end", busy, 0);
                chk("score_idle", score, score_m);
                return;
            end
            s = exp_q.pop_front();
            bad = 0;
            repeat (s - base + 1) begin
                if (busy !== 1'b1 || hit !== 1'b0) bad++;
                bus.retire_ack = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            bus.retire_ack = 1'b0;
            chk("scan_quiet", bad, 0);
            score_m = (score_m >= SAT) ? SAT : score_m + 1;
            chk("hit", hit, 1);
            chk("duck_kill", duck_kill, first);
            chk("retire_req", bus.retire_req, 1);
            chk("retire_slot", bus.retire_slot, s);
            chk("score", score, score_m);
            first = 1'b0;
            bad = 0;
            repeat (ack_dly) begin
                @(negedge clk);
                if (bus.retire_req !== 1'b1 || bus.retire_slot !== s[2:0] || hit !== 1'b0 ||
                    duck_kill !== 1'b0 || busy !== 1'b1 || score !== score_m[SCORE_W-1:0]) bad++;
            end
            chk("report_hold", bad, 0);
            bus.retire_ack = 1'b1;
            @(negedge clk);
            bus.retire_ack = 1'b0;
            chk("done_req", bus.retire_req, 0);
            chk("done_busy", busy, 1);
            @(negedge clk);
            if (MULTI && s < NS - 1) begin
                chk("rescan", busy, 1);
                base = s + 1;
            end else begin
                chk("idle_after_done", busy, 0);
                return;
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_req"},   bus.retire_req, 0);
        chk({tag, "_slot"},  bus.retire_slot, 0);
        chk({tag, "_hit"},   hit, 0);
        chk({tag, "_kill"},  duck_kill, 0);
        chk({tag, "_score"}, score, 0);
        chk({tag, "_busy"},  busy, 0);
    endtask

    initial begin
        int c, n;
        clear_all();
        apply();
        bus.retire_ack = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        reset = 1'b1;

        // basic single hit, ack three cycles after the request
        set_basic();
        run_pass(3);
        chk("first_pass_at", last_start, SCAN_DIV);

        // x exactly at the duck's right edge, and an inactive overlapping slot
        clear_all();
        act[0] = 1'b1; sx[0] = 128; sy[0] = 50;
        act[5] = 1'b0; sx[5] = 100; sy[5] = 50;
        apply();
        run_pass(0);

        // negative y just touching and just missing a duck at y=0
        clear_all();
        dy = 0;
        act[7] = 1'b1; sx[7] = 100; sy[7] = -5;
        apply();
        run_pass(1);
        sy[7] = -11;
        apply();
        run_pass(0);

        // dead duck ignores overlap
        set_basic();
        alive = 1'b0;
        apply();
        run_pass(0);

        // retire stuck across several ticks, then a normal pass on the next tick
        set_basic();
        run_pass(40);
        run_pass(0);

        // two overlapping slots
        clear_all();
        act[1] = 1'b1; sx[1] = 100; sy[1] = 50;
        act[4] = 1'b1; sx[4] = 110; sy[4] = 60;
        apply();
        run_pass(2);

        // async reset in the middle of a handshake
        set_basic();
        c = 0;
        while (hit !== 1'b1 && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("rst_pre_hit", hit, 1);
        #2 reset = 1'b0;
        #1 check_reset_values("midrst");
        score_m = 0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run_pass(0);
        chk("rst_first_pass_at", last_start, SCAN_DIV);

        repeat (250) begin
            randomize_inputs();
            run_pass($urandom_range(0, 3));
        end

        // drive the score into saturation
        set_basic();
        n = 0;
        while (score_m < SAT && n < 300) begin
            run_pass(0);
            n++;
        end
        run_pass(0);
        run_pass(1);
        chk("score_sat", score, SAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
